screen_sequencer: RTL and testbench

Top-level game-flow controller for the XGA (1024x768, 65 MHz) display path. Sequences the full-screen modules (start, capture, process, result) through a four-state FSM, issues their start/reset pulses, and muxes their pixel streams onto a single registered `pixel_out`. All screen changes are deferred to the frame boundary so no frame ever mixes two screens.

---
 rtl/screen_pkg.sv | 18 +
 rtl/frame_timeout.sv | 29 ++
 rtl/screen_sequencer.sv | 147 ++++++++++++++
 tb/tb_screen_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared screen identifiers and XGA timing constants used by the sequencer
// and by the full-screen display modules.
package screen_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    CAPTURE = 2'd1,
    PROCESS = 2'd2,
    RESULT  = 2'd3
  } screen_t;

  localparam int H_TOTAL     = 1344;
  localparam int V_TOTAL     = 806;
  localparam int H_ACTIVE    = 1024;
  localparam int V_ACTIVE    = 768;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/frame_timeout.sv
// Frame counter for the PROCESS screen; flags expiry once the configured
// number of frames has elapsed since the last clear.
module frame_timeout
  import screen_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [FRAME_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == FRAME_CNT_W'(TIMEOUT_FRAMES));

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller: sequences START/CAPTURE/PROCESS/RESULT screens,
// deferring every screen change to the frame boundary, and muxes the pixels.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int H_TOTAL        = screen_pkg::H_TOTAL,
  parameter int V_TOTAL        = screen_pkg::V_TOTAL,
  parameter int TIMEOUT_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        btnc_pressed,
  input  logic        start_over,
  input  logic        capture_done,
  input  logic        process_done,
  input  logic [11:0] pixel_start,
  input  logic [11:0] pixel_capture,
  input  logic [11:0] pixel_process,
  input  logic [11:0] pixel_result,
  output logic [11:0] pixel_out,
  output logic [1:0]  state,
  output logic        screen_rst,
  output logic        capture_start,
  output logic        process_start,
  output logic        timeout_err
);

  screen_t cur_state, next_state;
  screen_t pend_target, next_pend_target;
  logic    pend_valid, next_pend_valid;
  logic    next_timeout_err;
  logic    start_q;
  logic    frame_end;
  logic    expired;
  logic    count_en;
  logic [11:0] pixel_sel;

  assign frame_end = (hcount == 11'(H_TOTAL - 1)) && (vcount == 10'(V_TOTAL - 1));
  assign count_en  = (cur_state == PROCESS) && frame_end && !pend_valid;
  assign state     = cur_state;

  frame_timeout #(
    .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
  ) u_frame_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (process_start),
    .enable (count_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= START;
      pend_valid  <= 1'b0;
      pend_target <= START;
      timeout_err <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      cur_state   <= next_state;
      pend_valid  <= next_pend_valid;
      pend_target <= next_pend_target;
      timeout_err <= next_timeout_err;
      start_q     <= start_over;
    end
  end

  // A pending request commits on frame_end; new requests are only accepted while nothing is pending.
  always_comb begin
    next_state       = cur_state;
    next_pend_valid  = pend_valid;
    next_pend_target = pend_target;
    next_timeout_err = timeout_err;
    screen_rst       = 1'b0;
    capture_start    = 1'b0;
    process_start    = 1'b0;
    if (pend_valid) begin
      if (frame_end) begin
        next_state      = pend_target;
        next_pend_valid = 1'b0;
        case (pend_target)
          START:   screen_rst = 1'b1;
          CAPTURE: begin
            capture_start    = 1'b1;
            next_timeout_err = 1'b0;
          end
          PROCESS: process_start = 1'b1;
          default: ;
        endcase
      end
    end else begin
      case (cur_state)
        START: begin
          if (start_over && !start_q) begin
            next_pend_valid  = 1'b1;
            next_pend_target = CAPTURE;
          end
        end
        CAPTURE: begin
          if (capture_done) begin
            next_pend_valid  = 1'b1;
            next_pend_target = PROCESS;
          end
        end
        PROCESS: begin
          if (process_done) begin
            next_pend_valid  = 1'b1;
            next_pend_target = RESULT;
          end else if (expired) begin
            next_pend_valid  = 1'b1;
            next_pend_target = START;
            next_timeout_err = 1'b1;
          end
        end
        RESULT: begin
          if (btnc_pressed) begin
            next_pend_valid  = 1'b1;
            next_pend_target = START;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pixel_sel = 12'h000;
    case (cur_state)
      START:   pixel_sel = pixel_start;
      CAPTURE: pixel_sel = pixel_capture;
      PROCESS: pixel_sel = pixel_process;
      RESULT:  pixel_sel = pixel_result;
      default: pixel_sel = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out <= 12'h000;
    end else begin
      pixel_out <= pixel_sel;
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: directed screen-flow scenarios plus
// randomized traffic checked against a behavioural model of the game flow.
module tb_screen_sequencer;

  localparam int HT = 20;
  localparam int VT = 10;
  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        btnc_pressed, start_over, capture_done, process_done;
  logic [11:0] pix [4];
  logic [11:0] pixel_out;
  logic [1:0]  state;
  logic        screen_rst, capture_start, process_start, timeout_err;

  int n_compared = 0;
  int n_mismatched = 0;
  int h = 0;
  int v = 0;

  // behavioural model: m_pend = -1 means no request outstanding
  int m_state, m_pend, m_frames;
  bit m_terr, m_prev_start;
  logic [11:0] exp_pixel;
  int exp_state;
  bit exp_terr, exp_srst, exp_cs, exp_ps;
  bit obs_srst, obs_cs, obs_ps;

  screen_sequencer #(
    .H_TOTAL(HT), .V_TOTAL(VT), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .btnc_pressed(btnc_pressed), .start_over(start_over),
    .capture_done(capture_done), .process_done(process_done),
    .pixel_start(pix[0]), .pixel_capture(pix[1]),
    .pixel_process(pix[2]), .pixel_result(pix[3]),
    .pixel_out(pixel_out), .state(state), .screen_rst(screen_rst),
    .capture_start(capture_start), .process_start(process_start),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_pend = -1; m_frames = 0; m_terr = 0; m_prev_start = 0;
    exp_state = 0; exp_pixel = 12'h000; exp_terr = 0;
    exp_srst = 0; exp_cs = 0; exp_ps = 0;
  endtask

  task automatic model_cycle();
    bit fe;
    fe = (h == HT - 1) && (v == VT - 1);
    exp_srst = 0; exp_cs = 0; exp_ps = 0;
    exp_pixel = pix[m_state];
    if (m_pend >= 0) begin
      if (fe) begin
        if (m_pend == 0) exp_srst = 1;
        if (m_pend == 1) begin exp_cs = 1; m_terr = 0; end
        if (m_pend == 2) begin exp_ps = 1; m_frames = 0; end
        m_state = m_pend;
        m_pend = -1;
      end
    end else begin
      if (m_state == 0 && start_over && !m_prev_start) m_pend = 1;
      else if (m_state == 1 && capture_done) m_pend = 2;
      else if (m_state == 2 && process_done) m_pend = 3;
      else if (m_state == 2 && m_frames == TO) begin m_pend = 0; m_terr = 1; end
      else if (m_state == 3 && btnc_pressed) m_pend = 0;
      if (m_state == 2 && fe) m_frames++;
    end
    m_prev_start = start_over;
    exp_state = m_state;
    exp_terr = m_terr;
  endtask

  // one pixel clock: called at posedge+1, returns at the next posedge+1
  task automatic tick();
    #2;
    obs_srst = screen_rst; obs_cs = capture_start; obs_ps = process_start;
    model_cycle();
    @(posedge clk);
    #1;
    btnc_pressed = 0; capture_done = 0; process_done = 0;
    h++;
    if (h == HT) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end
    hcount = 11'(h);
    vcount = 10'(v);
  endtask

  task automatic run_to(input int th, input int tv);
    int guard = 0;
    while (!(h == th && v == tv) && guard <= HT * VT) begin
      tick();
      guard++;
    end
    if (guard > HT * VT) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL run_to position (%0d,%0d) not reached, at (%0d,%0d)", th, tv, h, v);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; btnc_pressed = 0; start_over = 0; capture_done = 0; process_done = 0;
    hcount = 0; vcount = 0;
    pix[0] = 12'h111; pix[1] = 12'h222; pix[2] = 12'h333; pix[3] = 12'h444;
    repeat (3) @(posedge clk);
    #1;
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_state got %0d want 0", state); end
    n_compared++; if (pixel_out !== 12'h000) begin n_mismatched++; $display("[TB] FAIL reset_pixel got %h want 000", pixel_out); end
    n_compared++; if (screen_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_screen_rst got %b want 0", screen_rst); end
    n_compared++; if ({capture_start, process_start} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_starts got %b want 00", {capture_start, process_start}); end
    n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_timeout_err got %b want 0", timeout_err); end
    rst_n = 1;
    h = 0; v = 0;
    model_reset();
  endtask

  task automatic test_start_capture();
    bit early;
    run_to(10, 5);
    start_over = 1;
    early = 0;
    while (!(h == HT - 1 && v == VT - 1)) begin
      if (state !== 2'd0 || capture_start !== 1'b0) early = 1;
      tick();
    end
    n_compared++; if (early) begin n_mismatched++; $display("[TB] FAIL start_early_commit got early change want state 0 until frame end"); end
    tick();
    n_compared++; if (obs_cs !== 1'b1) begin n_mismatched++; $display("[TB] FAIL start_capture_pulse got %b want 1", obs_cs); end
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL start_state_at_origin got %0d want 1", state); end
    tick();
    n_compared++; if (obs_cs !== 1'b0) begin n_mismatched++; $display("[TB] FAIL start_pulse_width got %b want 0", obs_cs); end
    n_compared++; if (pixel_out !== 12'h222) begin n_mismatched++; $display("[TB] FAIL start_pixel got %h want 222", pixel_out); end
  endtask

  task automatic test_capture_to_process();
    capture_done = 1;
    tick();
    repeat (5) tick();
    btnc_pressed = 1;
    tick();
    run_to(HT - 1, VT - 1);
    tick();
    n_compared++; if (obs_ps !== 1'b1) begin n_mismatched++; $display("[TB] FAIL capture_process_pulse got %b want 1", obs_ps); end
    n_compared++; if (obs_srst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL capture_button_ignored got %b want 0", obs_srst); end
    n_compared++; if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL capture_state got %0d want 2", state); end
    tick();
    n_compared++; if (pixel_out !== 12'h333) begin n_mismatched++; $display("[TB] FAIL capture_pixel got %h want 333", pixel_out); end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= TO; k++) begin
      run_to(HT - 1, VT - 1);
      tick();
      n_compared++; if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL timeout_hold frame %0d got %0d want 2", k, state); end
    end
    run_to(HT - 1, VT - 1);
    tick();
    n_compared++; if (obs_srst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_screen_rst got %b want 1", obs_srst); end
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL timeout_state got %0d want 0", state); end
    n_compared++; if (timeout_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_err_set got %b want 1", timeout_err); end
    tick();
    n_compared++; if (pixel_out !== 12'h111) begin n_mismatched++; $display("[TB] FAIL timeout_pixel got %h want 111", pixel_out); end
  endtask

  task automatic test_done_vs_timeout();
    start_over = 0;
    tick();
    start_over = 1;
    tick();
    run_to(HT - 1, VT - 1);
    tick();
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL race_enter_capture got %0d want 1", state); end
    n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL race_err_cleared got %b want 0", timeout_err); end
    capture_done = 1;
    tick();
    run_to(HT - 1, VT - 1);
    tick();
    for (int k = 0; k < TO; k++) begin
      run_to(HT - 1, VT - 1);
      tick();
    end
    process_done = 1;
    tick();
    run_to(HT - 1, VT - 1);
    tick();
    n_compared++; if (state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL race_state got %0d want 3", state); end
    n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL race_timeout_err got %b want 0", timeout_err); end
    n_compared++; if (obs_srst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL race_no_screen_rst got %b want 0", obs_srst); end
    tick();
    n_compared++; if (pixel_out !== 12'h444) begin n_mismatched++; $display("[TB] FAIL race_pixel got %h want 444", pixel_out); end
  endtask

  task automatic test_result_reset();
    bit spurious;
    repeat (3) tick();
    btnc_pressed = 1;
    tick();
    repeat (10) tick();
    #2;
    rst_n = 0;
    #1;
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL midreset_state got %0d want 0", state); end
    n_compared++; if (pixel_out !== 12'h000) begin n_mismatched++; $display("[TB] FAIL midreset_pixel got %h want 000", pixel_out); end
    n_compared++; if (screen_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_screen_rst got %b want 0", screen_rst); end
    start_over = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    h = 0; v = 0; hcount = 0; vcount = 0;
    model_reset();
    spurious = 0;
    for (int c = 0; c < HT * VT + 2; c++) begin
      tick();
      if (obs_srst || obs_cs || obs_ps) spurious = 1;
    end
    n_compared++; if (spurious) begin n_mismatched++; $display("[TB] FAIL midreset_pending_dropped got pulse want none"); end
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL midreset_state_after got %0d want 0", state); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 12000; c++) begin
      for (int p = 0; p < 4; p++) pix[p] = 12'($urandom);
      btnc_pressed = ($urandom_range(0, 150) == 0);
      capture_done = ($urandom_range(0, 250) == 0);
      process_done = ($urandom_range(0, 500) == 0);
      if ($urandom_range(0, 100) == 0) start_over = ~start_over;
      tick();
      n_compared++; if (obs_srst !== exp_srst) begin n_mismatched++; $display("[TB] FAIL rand_screen_rst cycle %0d got %b want %b", c, obs_srst, exp_srst); end
      n_compared++; if (obs_cs !== exp_cs) begin n_mismatched++; $display("[TB] FAIL rand_capture_start cycle %0d got %b want %b", c, obs_cs, exp_cs); end
      n_compared++; if (obs_ps !== exp_ps) begin n_mismatched++; $display("[TB] FAIL rand_process_start cycle %0d got %b want %b", c, obs_ps, exp_ps); end
      n_compared++; if (state !== 2'(exp_state)) begin n_mismatched++; $display("[TB] FAIL rand_state cycle %0d got %0d want %0d", c, state, exp_state); end
      n_compared++; if (pixel_out !== exp_pixel) begin n_mismatched++; $display("[TB] FAIL rand_pixel cycle %0d got %h want %h", c, pixel_out, exp_pixel); end
      n_compared++; if (timeout_err !== exp_terr) begin n_mismatched++; $display("[TB] FAIL rand_timeout_err cycle %0d got %b want %b", c, timeout_err, exp_terr); end
    end
  endtask

  initial begin
    test_reset();
    test_start_capture();
    test_capture_to_process();
    test_timeout();
    test_done_vs_timeout();
    test_result_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
